// File: rtl/freq_calc_ctrl.sv
// -----------------------------------------------------------------------------
// freq_calc_ctrl
//   Sequencer for the gated frequency-counter datapath. A calc_flag_reg pulse
//   latches the two gate counts. The block then computes
//       freq = CLK_STAND_FREQ * cnt_clk_test_reg / cnt_clk_stand_reg
//   with a shift-add multiplier (CNT_W cycles) and a restoring divider
//   (PROD_W cycles, one quotient bit per cycle). The result is presented with
//   a one-cycle valid strobe.
//
// Ports
//   sys_clk            in   1       system clock, posedge
//   sys_rst_n          in   1       asynchronous active-low reset
//   calc_flag_reg      in   1       start pulse; counts stable while high
//   cnt_clk_stand_reg  in   CNT_W   standard-clock cycles in the real gate
//   cnt_clk_test_reg   in   CNT_W   test-clock cycles in the real gate
//   freq               out  FREQ_W  last computed frequency (Hz), held
//   freq_valid         out  1       one-cycle strobe, freq updated same edge
//   busy               out  1       computation in progress
//   calc_err           out  1       last result invalid (div by zero / saturated)
//   overrun            out  1       sticky: a start arrived while busy
// -----------------------------------------------------------------------------
module freq_calc_ctrl #(
    parameter logic [27:0] CLK_STAND_FREQ = 28'd60_000_000,
    parameter int          CNT_W          = 28,
    parameter int          FREQ_W         = 34
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              calc_flag_reg,
    input  logic [CNT_W-1:0]  cnt_clk_stand_reg,
    input  logic [CNT_W-1:0]  cnt_clk_test_reg,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              busy,
    output logic              calc_err,
    output logic              overrun
);

    localparam int PROD_W = CNT_W + 28;
    localparam int BC_W   = $clog2(PROD_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t            state_q;
    logic [PROD_W-1:0] mcand_q;   // shifted CLK_STAND_FREQ
    logic [PROD_W-1:0] acc_q;     // product, then dividend/quotient shift register
    logic [CNT_W-1:0]  mplier_q;  // test count, consumed LSB first
    logic [CNT_W-1:0]  divisor_q; // stand count
    logic [CNT_W-1:0]  rem_q;     // partial remainder (always < divisor)
    logic [BC_W-1:0]   bcnt_q;

    logic [FREQ_W-1:0] freq_q;
    logic              freq_valid_q;
    logic              calc_err_q;
    logic              overrun_q;

    // Restoring divide step. The working remainder is CNT_W+1 bits wide so the
    // shifted-in value can exceed the largest divisor without wrapping.
    logic [CNT_W:0]    rem_sh_d;
    logic [CNT_W:0]    rem_diff_d;
    logic              q_bit_d;
    logic [CNT_W-1:0]  rem_d;

    always_comb begin
        rem_sh_d   = {rem_q, acc_q[PROD_W-1]};
        rem_diff_d = rem_sh_d - {1'b0, divisor_q};
        q_bit_d    = (rem_sh_d >= {1'b0, divisor_q});
        rem_d      = q_bit_d ? CNT_W'(rem_diff_d) : CNT_W'(rem_sh_d);
    end

    // Returns {err, value}: any quotient bit above FREQ_W forces all ones.
    function automatic logic [FREQ_W:0] sat_quot(input logic [PROD_W-1:0] q);
        if (|q[PROD_W-1:FREQ_W])
            return {1'b1, {FREQ_W{1'b1}}};
        else
            return {1'b0, q[FREQ_W-1:0]};
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            bcnt_q       <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            calc_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (calc_flag_reg) begin
                        mcand_q   <= {{(PROD_W-28){1'b0}}, CLK_STAND_FREQ};
                        mplier_q  <= cnt_clk_test_reg;
                        divisor_q <= cnt_clk_stand_reg;
                        acc_q     <= '0;
                        rem_q     <= '0;
                        bcnt_q    <= '0;
                        overrun_q <= 1'b0;
                        if (cnt_clk_stand_reg == '0) begin
                            // Division by zero: report immediately, no run.
                            freq_q       <= '0;
                            calc_err_q   <= 1'b1;
                            freq_valid_q <= 1'b1;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end

                MUL: begin
                    if (calc_flag_reg)
                        overrun_q <= 1'b1;
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (bcnt_q == BC_W'(CNT_W - 1)) begin
                        bcnt_q  <= '0;
                        state_q <= DIV;
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end

                DIV: begin
                    if (calc_flag_reg)
                        overrun_q <= 1'b1;
                    if (bcnt_q == BC_W'(PROD_W)) begin
                        // All quotient bits are in acc_q; publish the result.
                        {calc_err_q, freq_q} <= sat_quot(acc_q);
                        freq_valid_q         <= 1'b1;
                        state_q              <= IDLE;
                    end else begin
                        // Dividend MSB moves into the remainder, quotient bit
                        // enters at the LSB of the same register.
                        acc_q  <= {acc_q[PROD_W-2:0], q_bit_d};
                        rem_q  <= rem_d;
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign busy       = (state_q != IDLE);
    assign calc_err   = calc_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_freq_calc_ctrl.sv
module tb_freq_calc_ctrl;

    localparam int CNT_W  = 28;
    localparam int FREQ_W = 34;
    localparam int LAT    = 85;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              calc_flag_reg;
    logic [CNT_W-1:0]  cnt_clk_stand_reg;
    logic [CNT_W-1:0]  cnt_clk_test_reg;
    logic [FREQ_W-1:0] freq;
    logic              freq_valid;
    logic              busy;
    logic              calc_err;
    logic              overrun;

    freq_calc_ctrl dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .calc_flag_reg     (calc_flag_reg),
        .cnt_clk_stand_reg (cnt_clk_stand_reg),
        .cnt_clk_test_reg  (cnt_clk_test_reg),
        .freq              (freq),
        .freq_valid        (freq_valid),
        .busy              (busy),
        .calc_err          (calc_err),
        .overrun           (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Posedge counter; at a negedge it equals the index of the last posedge.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [FREQ_W-1:0] freq;
        logic              err;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain 64-bit integer arithmetic.
    function automatic exp_t model(input logic [CNT_W-1:0] stand,
                                   input logic [CNT_W-1:0] test, input int e0);
        exp_t e;
        longint unsigned q;
        if (stand == 0) begin
            e.freq = '0; e.err = 1'b1; e.due = e0;
        end else begin
            q = (64'd60_000_000 * longint'(test)) / longint'(stand);
            if (q > 64'h3_FFFF_FFFF) begin
                e.freq = '1; e.err = 1'b1;
            end else begin
                e.freq = q[FREQ_W-1:0]; e.err = 1'b0;
            end
            e.due = e0 + LAT;
        end
        return e;
    endfunction

    // Pulses calc_flag_reg for one edge (E0), pushes the expectation,
    // returns 1 ns after E0.
    task automatic start(input logic [CNT_W-1:0] stand, input logic [CNT_W-1:0] test);
        @(negedge sys_clk);
        cnt_clk_stand_reg = stand;
        cnt_clk_test_reg  = test;
        calc_flag_reg     = 1'b1;
        sb.push_back(model(stand, test, cyc + 1));
        @(posedge sys_clk);
        #1 calc_flag_reg = 1'b0;
    endtask

    // Waits for freq_valid, pops the scoreboard and compares value, error flag
    // and arrival cycle; then checks the strobe is only one cycle wide.
    task automatic wait_result(input string name, input int budget, output logic busy_at);
        exp_t e;
        bit   got = 0;
        busy_at = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge sys_clk);
            if (freq_valid) got = 1;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty got_valid=%0b", name, got);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout waiting freq_valid (budget %0d)", name, budget);
            return;
        end
        busy_at = busy;
        if (freq !== e.freq) begin
            errors++;
            $display("FAIL %s freq got %0d want %0d", name, freq, e.freq);
        end
        checks++;
        if (calc_err !== e.err) begin
            errors++;
            $display("FAIL %s calc_err got %0b want %0b", name, calc_err, e.err);
        end
        checks++;
        if (cyc !== e.due) begin
            errors++;
            $display("FAIL %s latency valid at edge %0d want %0d", name, cyc, e.due);
        end
        @(negedge sys_clk);
        checks++;
        if (freq_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after-strobe valid=%0b busy=%0b want 0/0", name, freq_valid, busy);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        calc_flag_reg = 1'b0;
        cnt_clk_stand_reg = '0;
        cnt_clk_test_reg = '0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({freq, freq_valid, busy, calc_err, overrun} !== '0) begin
            errors++;
            $display("FAIL reset outputs got freq=%0d v=%0b b=%0b e=%0b o=%0b want all 0",
                     freq, freq_valid, busy, calc_err, overrun);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic b;
        start(28'd2_000_000, 28'd1_000_000);
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic busy got %0b want 1", busy);
        end
        wait_result("basic", 120, b);
        checks++;
        if (freq !== 34'd30_000_000) begin
            errors++;
            $display("FAIL basic held freq got %0d want 30000000", freq);
        end
    endtask

    task automatic test_exact();
        logic b;
        start(28'd21_000_000, 28'd21_000_000); wait_result("exact_equal", 120, b);
        start(28'd3, 28'd1);                   wait_result("exact_div3", 120, b);
        start(28'd7, 28'd1);                   wait_result("floor_div7", 120, b);
        start(28'd2_000_000, 28'd0);           wait_result("test_zero", 120, b);
    endtask

    task automatic test_div_zero();
        logic b;
        start(28'd0, 28'd5);
        wait_result("div_zero", 5, b);
        checks++;
        if (b !== 1'b0) begin
            errors++;
            $display("FAIL div_zero busy at valid got %0b want 0", b);
        end
    endtask

    task automatic test_saturate();
        logic b;
        start(28'd1, 28'hFFF_FFFF);
        wait_result("saturate", 120, b);
        start(28'hFFF_FFFF, 28'hFFF_FFFF);
        wait_result("max_counts", 120, b);
    endtask

    task automatic test_random();
        logic b;
        logic [CNT_W-1:0] s, t;
        for (int i = 0; i < 4; i++) begin
            s = CNT_W'($urandom_range(1, 50_000_000));
            t = CNT_W'($urandom_range(0, 50_000_000));
            start(s, t);
            wait_result("random", 120, b);
        end
    endtask

    task automatic test_overrun();
        logic b;
        start(28'd2_000_000, 28'd1_000_000);
        repeat (40) @(negedge sys_clk);
        cnt_clk_stand_reg = 28'd1;
        cnt_clk_test_reg  = 28'd5;
        calc_flag_reg     = 1'b1;
        @(negedge sys_clk);
        calc_flag_reg = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun set got ovr=%0b busy=%0b want 1/1", overrun, busy);
        end
        wait_result("overrun_ignored", 120, b);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky got %0b want 1", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic b;
        start(28'd3, 28'd1);
        @(negedge sys_clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b overrun clear got %0b want 0", overrun);
        end
        wait_result("b2b_first", 120, b);
        start(28'd2_000_000, 28'd1_000_000);
        wait_result("b2b_second", 120, b);
    endtask

    task automatic test_reset_mid();
        logic b;
        bit   seen = 0;
        start(28'd2_000_000, 28'd1_000_000);
        repeat (50) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({freq, freq_valid, busy, calc_err, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got freq=%0d v=%0b b=%0b e=%0b o=%0b want all 0",
                     freq, freq_valid, busy, calc_err, overrun);
        end
        sb.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (freq_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid spurious freq_valid got 1 want 0");
        end
        start(28'd2_000_000, 28'd1_000_000);
        wait_result("reset_mid_rerun", 120, b);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exact();
        test_div_zero();
        test_saturate();
        test_random();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
